// File: rtl/minimips_pkg.sv
// Shared MiniMIPS datapath definitions: default widths, register-file geometry and word/index types.
package minimips_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 3;
  localparam int unsigned REG_COUNT  = 2 ** DEF_ADDR_W;
  localparam int unsigned ZERO_REG   = 0;

  typedef logic [DEF_DATA_W-1:0] reg_word_t;
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: word select, register-0 force and optional write-through forwarding.
module regfile_read_port
  import minimips_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter bit          BYPASS = 1'b1
) (
  input  logic [ADDR_W-1:0]                     rd_addr,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]    words,
  input  logic                                  fwd_en,
  input  logic [ADDR_W-1:0]                     wr_addr,
  input  logic [DATA_W-1:0]                     wr_data,
  output logic [DATA_W-1:0]                     rd_data
);

  always_comb begin
    rd_data = words[rd_addr];
    if (rd_addr == '0) begin
      rd_data = '0;
    end
    // fwd_en already excludes register 0 and reset, so a hit is always a real write
    if (BYPASS && fwd_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
  end

endmodule

// File: rtl/mini_regfile.sv
// Two-read/one-write register file for MiniMIPS; register 0 reads as zero and holds no storage.
module mini_regfile
  import minimips_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              wr_ack
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:1][DATA_W-1:0] mem;
  logic [DEPTH-1:0][DATA_W-1:0] words;
  logic                         wr_fire;
  logic                         fwd_en;

  assign wr_fire = we && (wr_addr != '0);
  // Forwarding is masked during reset so reads stay zero for any address
  assign fwd_en  = wr_fire && rst_n;
  assign words   = {mem, {DATA_W{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= wr_fire;
      if (wr_fire) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port1 (
    .rd_addr (rd_addr1),
    .words   (words),
    .fwd_en  (fwd_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_data (rd_data1)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port2 (
    .rd_addr (rd_addr2),
    .words   (words),
    .fwd_en  (fwd_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_data (rd_data2)
  );

endmodule

// File: tb/tb_mini_regfile.sv
// Directed bench driving one BYPASS=0 and one BYPASS=1 register file with identical stimulus.
module tb_mini_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [2:0]  rd_addr1 = '0;
  logic [2:0]  rd_addr2 = '0;
  logic [31:0] rd1_nb, rd2_nb, rd1_bp, rd2_bp;
  logic        ack_nb, ack_bp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mini_regfile #(.DATA_W(32), .ADDR_W(3), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd1_nb), .rd_data2(rd2_nb),
    .wr_ack(ack_nb)
  );

  mini_regfile #(.DATA_W(32), .ADDR_W(3), .BYPASS(1'b1)) dut_bp (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd1_bp), .rd_data2(rd2_bp),
    .wr_ack(ack_bp)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    for (int a = 0; a < 8; a++) begin
      rd_addr1 = 3'(a);
      rd_addr2 = 3'(7 - a);
      #1;
      n_checks++;
      if (rd1_nb !== 32'h0 || rd2_nb !== 32'h0 || rd1_bp !== 32'h0 || rd2_bp !== 32'h0) begin
        $display("FAIL reset_read a=%0d got %h %h %h %h want 0", a, rd1_nb, rd2_nb, rd1_bp, rd2_bp);
        n_fail++;
      end
    end
    n_checks++;
    if (ack_nb !== 1'b0 || ack_bp !== 1'b0) begin
      $display("FAIL reset_ack got %b %b want 0", ack_nb, ack_bp);
      n_fail++;
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    we = 1'b1; wr_addr = 3'd1; wr_data = 32'hFFFF_FFFF;
    tick();
    n_checks++;
    if (ack_nb !== 1'b1 || ack_bp !== 1'b1) begin
      $display("FAIL wr1_ack got %b %b want 1", ack_nb, ack_bp);
      n_fail++;
    end
    wr_addr = 3'd2; wr_data = 32'h40A0_0400;
    tick();
    n_checks++;
    if (ack_nb !== 1'b1 || ack_bp !== 1'b1) begin
      $display("FAIL wr2_ack got %b %b want 1", ack_nb, ack_bp);
      n_fail++;
    end
    we = 1'b0; rd_addr1 = 3'd1; rd_addr2 = 3'd2;
    #1;
    n_checks++;
    if (rd1_nb !== 32'hFFFF_FFFF || rd1_bp !== 32'hFFFF_FFFF) begin
      $display("FAIL read_r1 got %h %h want ffffffff", rd1_nb, rd1_bp);
      n_fail++;
    end
    n_checks++;
    if (rd2_nb !== 32'h40A0_0400 || rd2_bp !== 32'h40A0_0400) begin
      $display("FAIL read_r2 got %h %h want 40a00400", rd2_nb, rd2_bp);
      n_fail++;
    end
    tick();
    n_checks++;
    if (ack_nb !== 1'b0 || ack_bp !== 1'b0) begin
      $display("FAIL wr_ack_drop got %b %b want 0", ack_nb, ack_bp);
      n_fail++;
    end
  endtask

  task automatic test_zero_write;
    rd_addr1 = 3'd0; rd_addr2 = 3'd0;
    we = 1'b1; wr_addr = 3'd0; wr_data = 32'h2222_0225;
    #1;
    n_checks++;
    if (rd1_nb !== 32'h0 || rd1_bp !== 32'h0 || rd2_bp !== 32'h0) begin
      $display("FAIL r0_before got %h %h %h want 0", rd1_nb, rd1_bp, rd2_bp);
      n_fail++;
    end
    tick();
    we = 1'b0;
    n_checks++;
    if (ack_nb !== 1'b0 || ack_bp !== 1'b0) begin
      $display("FAIL r0_ack got %b %b want 0", ack_nb, ack_bp);
      n_fail++;
    end
    #1;
    n_checks++;
    if (rd1_nb !== 32'h0 || rd1_bp !== 32'h0 || rd2_nb !== 32'h0) begin
      $display("FAIL r0_after got %h %h %h want 0", rd1_nb, rd1_bp, rd2_nb);
      n_fail++;
    end
  endtask

  task automatic test_bypass;
    we = 1'b1; wr_addr = 3'd3; wr_data = 32'h1111_1111;
    tick();
    wr_data = 32'hC242_0423; rd_addr1 = 3'd3; rd_addr2 = 3'd3;
    #1;
    n_checks++;
    if (rd1_bp !== 32'hC242_0423 || rd2_bp !== 32'hC242_0423) begin
      $display("FAIL bypass_fwd got %h %h want c2420423", rd1_bp, rd2_bp);
      n_fail++;
    end
    n_checks++;
    if (rd1_nb !== 32'h1111_1111 || rd2_nb !== 32'h1111_1111) begin
      $display("FAIL nobypass_old got %h %h want 11111111", rd1_nb, rd2_nb);
      n_fail++;
    end
    // Forwarding on one port only: the other port reads a different register
    rd_addr2 = 3'd1;
    #1;
    n_checks++;
    if (rd1_bp !== 32'hC242_0423 || rd2_bp !== 32'hFFFF_FFFF) begin
      $display("FAIL bypass_single got %h %h want c2420423 ffffffff", rd1_bp, rd2_bp);
      n_fail++;
    end
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if (rd1_nb !== 32'hC242_0423 || rd1_bp !== 32'hC242_0423) begin
      $display("FAIL bypass_stored got %h %h want c2420423", rd1_nb, rd1_bp);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back;
    we = 1'b1; wr_addr = 3'd5; wr_data = 32'hAAAA_AAAA;
    tick();
    n_checks++;
    if (ack_nb !== 1'b1 || ack_bp !== 1'b1) begin
      $display("FAIL b2b_ack1 got %b %b want 1", ack_nb, ack_bp);
      n_fail++;
    end
    wr_data = 32'h5555_5555;
    tick();
    n_checks++;
    if (ack_nb !== 1'b1 || ack_bp !== 1'b1) begin
      $display("FAIL b2b_ack2 got %b %b want 1", ack_nb, ack_bp);
      n_fail++;
    end
    we = 1'b0; rd_addr1 = 3'd5; rd_addr2 = 3'd5;
    #1;
    n_checks++;
    if (rd1_nb !== 32'h5555_5555 || rd2_bp !== 32'h5555_5555) begin
      $display("FAIL b2b_data got %h %h want 55555555", rd1_nb, rd2_bp);
      n_fail++;
    end
    tick();
    n_checks++;
    if (ack_nb !== 1'b0 || ack_bp !== 1'b0) begin
      $display("FAIL b2b_ack_end got %b %b want 0", ack_nb, ack_bp);
      n_fail++;
    end
  endtask

  task automatic test_async_reset;
    we = 1'b1; wr_addr = 3'd6; wr_data = 32'hDEAD_BEEF;
    tick();
    we = 1'b0; rd_addr1 = 3'd6; rd_addr2 = 3'd5;
    #1;
    n_checks++;
    if (ack_nb !== 1'b1 || rd1_nb !== 32'hDEAD_BEEF) begin
      $display("FAIL pre_reset got ack=%b r6=%h want 1 deadbeef", ack_nb, rd1_nb);
      n_fail++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ack_nb !== 1'b0 || ack_bp !== 1'b0) begin
      $display("FAIL async_ack got %b %b want 0", ack_nb, ack_bp);
      n_fail++;
    end
    n_checks++;
    if (rd1_nb !== 32'h0 || rd2_nb !== 32'h0 || rd1_bp !== 32'h0 || rd2_bp !== 32'h0) begin
      $display("FAIL async_read got %h %h %h %h want 0", rd1_nb, rd2_nb, rd1_bp, rd2_bp);
      n_fail++;
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset_write;
    we = 1'b1; wr_addr = 3'd4; wr_data = 32'h1234_5678;
    rd_addr1 = 3'd4; rd_addr2 = 3'd4;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd1_bp !== 32'h0 || rd2_nb !== 32'h0) begin
      $display("FAIL rstwr_during got %h %h want 0", rd1_bp, rd2_nb);
      n_fail++;
    end
    tick();
    n_checks++;
    if (ack_nb !== 1'b0 || ack_bp !== 1'b0) begin
      $display("FAIL rstwr_ack got %b %b want 0", ack_nb, ack_bp);
      n_fail++;
    end
    we = 1'b0;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (ack_nb !== 1'b0 || ack_bp !== 1'b0) begin
      $display("FAIL rstwr_ack_after got %b %b want 0", ack_nb, ack_bp);
      n_fail++;
    end
    n_checks++;
    if (rd1_nb !== 32'h0 || rd1_bp !== 32'h0) begin
      $display("FAIL rstwr_r4 got %h %h want 0", rd1_nb, rd1_bp);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_write();
    test_bypass();
    test_back_to_back();
    test_async_reset();
    test_reset_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
